// File: rtl/tin_acc_ctrl.sv
// tin_acc_ctrl: sequences Tin-wide beats through the adder tree, tags them through its latency and
// accumulates num_pass tree outputs per result, cfg_num_out results per job.
// Optional feature: define TIN_ACC_CTRL_SAT_EN for saturating accumulation with a sticky o_sat flag.
module tin_acc_ctrl #(
    parameter int TIN        = 8,
    parameter int LOG2_TIN   = 3,
    parameter int DATA_WIDTH = 16,
    parameter int TREE_LAT   = 3,
    parameter int ACC_WIDTH  = 40,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_start,
    input  logic [CNT_WIDTH-1:0]           cfg_num_pass,
    input  logic [CNT_WIDTH-1:0]           cfg_num_out,
    output logic                           busy,
    output logic                           done,
    input  logic                           s_vld,
    output logic                           s_rdy,
    input  logic [DATA_WIDTH*TIN-1:0]      s_dat,
    output logic [DATA_WIDTH*TIN-1:0]      tree_i_dat,
    input  logic [DATA_WIDTH+LOG2_TIN-1:0] tree_o_dat,
    output logic                           o_vld,
    input  logic                           o_rdy,
    output logic [ACC_WIDTH-1:0]           o_dat,
    output logic                           o_sat
);
    localparam logic [TREE_LAT-1:0] LAST_TAG = TREE_LAT'(1) << (TREE_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] num_pass_q, num_pass_d, num_out_q, num_out_d;
    logic [CNT_WIDTH-1:0] pass_cnt_q, pass_cnt_d, out_cnt_q, out_cnt_d;
    logic [TREE_LAT-1:0]  en_q, first_q;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, o_dat_q, o_dat_d, ext;
    logic                 sat_q, sat_d, o_sat_q, o_sat_d, pend_q, pend_d, done_q, done_d;
    logic                 hs, tag_en, tag_first;

    assign hs         = s_vld && s_rdy;
    assign s_rdy      = state_q == RUN;
    assign o_vld      = state_q == OUT;
    assign busy       = state_q != IDLE;
    assign done       = done_q;
    assign o_dat      = o_dat_q;
    assign o_sat      = o_sat_q;
    assign tree_i_dat = hs ? s_dat : '0;
    assign tag_en     = en_q[TREE_LAT-1];
    assign tag_first  = first_q[TREE_LAT-1];
    assign ext        = ACC_WIDTH'($signed(tree_o_dat));
    // the last beat's tag is alone in the line and exiting: acc is final after this edge
    assign pend_d     = state_q == DRAIN && en_q == LAST_TAG;

`ifdef TIN_ACC_CTRL_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic [ACC_WIDTH:0] sum;
    logic               ovf;

    assign sum = tag_first ? {ext[ACC_WIDTH-1], ext} : {acc_q[ACC_WIDTH-1], acc_q} + {ext[ACC_WIDTH-1], ext};
    assign ovf = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];

    // saturating accumulate; flag is sticky within a result and restarts on its first beat
    always_comb begin
        acc_d = !tag_en ? acc_q : ovf ? (sum[ACC_WIDTH] ? ACC_MIN : ~ACC_MIN) : sum[ACC_WIDTH-1:0];
        sat_d = !tag_en ? sat_q : ovf || (!tag_first && sat_q);
    end
`else
    // wrapping accumulate; the first beat of a result restarts the sum
    always_comb begin
        acc_d = !tag_en ? acc_q : tag_first ? ext : acc_q + ext;
        sat_d = 1'b0;
    end
`endif

    // job sequencing: start, beat counting, drain wait, result hand-off
    always_comb begin
        state_d    = state_q;
        num_pass_d = num_pass_q;
        num_out_d  = num_out_q;
        pass_cnt_d = pass_cnt_q;
        out_cnt_d  = out_cnt_q;
        o_dat_d    = o_dat_q;
        o_sat_d    = o_sat_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: if (cfg_start) begin
                num_pass_d = cfg_num_pass == '0 ? CNT_WIDTH'(1) : cfg_num_pass;
                num_out_d  = cfg_num_out == '0 ? CNT_WIDTH'(1) : cfg_num_out;
                pass_cnt_d = '0;
                out_cnt_d  = '0;
                state_d    = RUN;
            end
            RUN: if (hs) begin
                pass_cnt_d = pass_cnt_q == num_pass_q - CNT_WIDTH'(1) ? '0 : pass_cnt_q + CNT_WIDTH'(1);
                state_d    = pass_cnt_q == num_pass_q - CNT_WIDTH'(1) ? DRAIN : RUN;
            end
            DRAIN: if (pend_q) begin
                o_dat_d = acc_q;
                o_sat_d = sat_q;
                state_d = OUT;
            end
            OUT: if (o_rdy) begin
                out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
                done_d    = out_cnt_q == num_out_q - CNT_WIDTH'(1);
                state_d   = out_cnt_q == num_out_q - CNT_WIDTH'(1) ? IDLE : RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // state, tag line and datapath registers; reset drops any in-flight beats and partial sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            num_pass_q <= '0;
            num_out_q  <= '0;
            pass_cnt_q <= '0;
            out_cnt_q  <= '0;
            en_q       <= '0;
            first_q    <= '0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            o_dat_q    <= '0;
            o_sat_q    <= 1'b0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_pass_q <= num_pass_d;
            num_out_q  <= num_out_d;
            pass_cnt_q <= pass_cnt_d;
            out_cnt_q  <= out_cnt_d;
            en_q       <= TREE_LAT'({en_q, hs});
            first_q    <= TREE_LAT'({first_q, hs && pass_cnt_q == '0});
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            o_dat_q    <= o_dat_d;
            o_sat_q    <= o_sat_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_tin_acc_ctrl.sv
// tb_tin_acc_ctrl: directed table-driven bench; a 40-bit and a 20-bit accumulator instance run in lockstep
// behind a behavioural 3-cycle Tin=8 adder tree.
module tb_tin_acc_ctrl;
    logic          clk = 1'b0;
    logic          rst_n, cfg_start, s_vld, o_rdy;
    logic [15:0]   cfg_num_pass, cfg_num_out;
    logic [127:0]  s_dat, tree_i_a, tree_i_b;
    logic signed [18:0] tree_sum, tp0, tp1, tp2;
    logic          busy, done, s_rdy, o_vld, o_sat;
    logic          busy_b, done_b, s_rdy_b, o_vld_b, o_sat_b;
    logic [39:0]   o_dat;
    logic [19:0]   o_dat_b;
    int            n_run = 0, n_fail = 0;

`ifdef TIN_ACC_CTRL_SAT_EN
    localparam longint BIG_B = 524287;
    localparam logic   BIG_S = 1'b1;
`else
    localparam longint BIG_B = -64;
    localparam logic   BIG_S = 1'b0;
`endif

    always #5 clk = ~clk;

    tin_acc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_num_pass(cfg_num_pass), .cfg_num_out(cfg_num_out),
        .busy(busy), .done(done), .s_vld(s_vld), .s_rdy(s_rdy), .s_dat(s_dat), .tree_i_dat(tree_i_a),
        .tree_o_dat(tp2), .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat), .o_sat(o_sat)
    );

    tin_acc_ctrl #(.ACC_WIDTH(20)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_num_pass(cfg_num_pass), .cfg_num_out(cfg_num_out),
        .busy(busy_b), .done(done_b), .s_vld(s_vld), .s_rdy(s_rdy_b), .s_dat(s_dat), .tree_i_dat(tree_i_b),
        .tree_o_dat(tp2), .o_vld(o_vld_b), .o_rdy(o_rdy), .o_dat(o_dat_b), .o_sat(o_sat_b)
    );

    // behavioural Tin_acc: sum of 8 signed lanes, three register stages
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < 8; i++) tree_sum += 19'($signed(tree_i_a[i*16 +: 16]));
    end

    always_ff @(posedge clk) begin
        tp0 <= tree_sum;
        tp1 <= tp0;
        tp2 <= tp1;
    end

    typedef struct packed {
        logic             start, last, gap;
        logic [15:0]      np, no;
        int               beats, hold;
        logic [7:0][15:0] lane;
        longint           exp_a, exp_b;
        logic             sat_b;
    } vec_t;

    function automatic vec_t mk(input logic st, la, input int np, no, hold, input logic gp, input int beats,
                                input int l0, l1, l2, l3, l4, l5, l6, l7, input longint ea, eb, input logic sb);
        vec_t v;
        v.start = st; v.last = la; v.gap = gp; v.np = 16'(np); v.no = 16'(no);
        v.beats = beats; v.hold = hold; v.exp_a = ea; v.exp_b = eb; v.sat_b = sb;
        v.lane[0] = 16'(l0); v.lane[1] = 16'(l1); v.lane[2] = 16'(l2); v.lane[3] = 16'(l3);
        v.lane[4] = 16'(l4); v.lane[5] = 16'(l5); v.lane[6] = 16'(l6); v.lane[7] = 16'(l7);
        return v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // one result: optional start, beats, latency, optional o_rdy stall, hand-off
    task automatic run_vec(input vec_t v);
        int to;
        int lat;
        logic [39:0] held;
        if (v.start) begin
            cfg_start = 1'b1; cfg_num_pass = v.np; cfg_num_out = v.no;
            @(negedge clk);
            cfg_start = 1'b0;
            chk("busy_after_start", busy, 1);
        end else begin
            cfg_start = 1'b1; cfg_num_pass = 16'd7; cfg_num_out = 16'd5;
        end
        for (int b = 0; b < v.beats; b++) begin
            s_vld = 1'b1;
            s_dat = {8{v.lane[b]}};
            to = 0;
            while (!s_rdy && to < 50) begin
                @(negedge clk);
                to++;
            end
            if (to >= 50) chk("beat_timeout", to, 0);
            @(negedge clk);
            if (v.gap && b == 0) begin
                s_vld = 1'b0;
                repeat (2) @(negedge clk);
            end
        end
        s_vld = 1'b0;
        cfg_start = 1'b0;
        lat = 0;
        while (!o_vld && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 4);
        held = o_dat;
        for (int h = 0; h < v.hold; h++) begin
            s_vld = 1'b1;
            s_dat = {8{16'h0063}};
            @(negedge clk);
            chk("hold_vld", o_vld && o_vld_b, 1);
            chk("hold_dat", longint'(o_dat == held), 1);
            chk("hold_srdy", s_rdy || s_rdy_b, 0);
            chk("hold_tree_gate", longint'(tree_i_a == '0 && tree_i_b == '0), 1);
        end
        s_vld = 1'b0;
        chk("o_dat_a", longint'($signed(o_dat)), v.exp_a);
        chk("o_dat_b", longint'($signed(o_dat_b)), v.exp_b);
        chk("o_sat_a", o_sat, 0);
        chk("o_sat_b", o_sat_b, longint'(v.sat_b));
        o_rdy = 1'b1;
        @(negedge clk);
        o_rdy = 1'b0;
        if (v.last) begin
            chk("done_pulse", done && done_b, 1);
            chk("busy_cleared", busy || busy_b, 0);
            @(negedge clk);
            chk("done_once", done || done_b, 0);
        end else begin
            chk("back_to_run", s_rdy && s_rdy_b, 1);
            chk("no_early_done", done, 0);
        end
    endtask

    vec_t tbl[7];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = mk(1, 1, 4, 1, 0, 0, 4, 1, 1, 1, 1, 0, 0, 0, 0, 32, 32, 0);
        tbl[1] = mk(1, 0, 3, 2, 10, 0, 3, -5, 7, 0, 0, 0, 0, 0, 0, 16, 16, 0);
        tbl[2] = mk(0, 1, 3, 2, 0, 1, 3, 1, 1, 1, 0, 0, 0, 0, 0, 24, 24, 0);
        tbl[3] = mk(1, 1, 0, 0, 0, 0, 1, 32767, 0, 0, 0, 0, 0, 0, 0, 262136, 262136, 0);
        tbl[4] = mk(1, 1, 5, 1, 0, 1, 5, 100, -200, 300, -400, 500, 0, 0, 0, 2400, 2400, 0);
        tbl[5] = mk(1, 1, 2, 1, 0, 0, 2, -32768, -32768, 0, 0, 0, 0, 0, 0, -524288, -524288, 0);
        tbl[6] = mk(1, 1, 8, 1, 0, 0, 8, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767,
                    2097088, BIG_B, BIG_S);
        rst_n = 1'b0; cfg_start = 1'b0; cfg_num_pass = '0; cfg_num_out = '0;
        s_vld = 1'b0; s_dat = '0; o_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s_rdy", s_rdy, 0);
        chk("rst_o_vld", o_vld, 0);
        chk("rst_o_dat", longint'(o_dat), 0);
        chk("rst_o_sat", o_sat, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 7; k++) run_vec(tbl[k]);
        cfg_start = 1'b1; cfg_num_pass = 16'd4; cfg_num_out = 16'd1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            s_vld = 1'b1;
            s_dat = {8{16'd9}};
            @(negedge clk);
        end
        s_vld = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_s_rdy", s_rdy, 0);
        chk("midrst_o_vld", o_vld, 0);
        chk("midrst_o_dat", longint'(o_dat), 0);
        chk("midrst_o_sat", o_sat, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("midrst_no_done", done || o_vld, 0);
        end
        run_vec(mk(1, 1, 2, 1, 0, 0, 2, 2, 2, 0, 0, 0, 0, 0, 0, 32, 32, 0));
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
